fsm_calc_stream: RTL and testbench
==================================

FSM_CALC_STREAM -- requirements
Module: fsm_calc_stream

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand width in bits; legal range is 4 to 32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a transaction; honoured only in IDLE.
REQ-005 abort  input  1  synchronous abort; returns the block to IDLE from any state.
REQ-006 in_valid  input  1  in_data holds a valid word.
REQ-007 in_data  input  WIDTH  operand A, operand B or opcode (bits [2:0]), by state.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  result and error are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  2*WIDTH  operation result.
REQ-012 error  output  1  reserved opcode flag, qualified by out_valid.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, LOAD_A, LOAD_B, LOAD_OP, EXEC, MUL and DONE.
REQ-015 Transitions:
- IDLE -> LOAD_A on start.
- LOAD_A -> LOAD_B, LOAD_B -> LOAD_OP and LOAD_OP -> EXEC, each on the in_valid && in_ready handshake.
- EXEC -> MUL when the opcode is MUL; otherwise EXEC -> DONE.
- MUL -> DONE after exactly WIDTH cycles in MUL.
- DONE -> IDLE on out_ready.
REQ-016 in_ready SHALL be high only in LOAD_A, LOAD_B and LOAD_OP; the block SHALL hold state while in_valid is low.
REQ-017 On a handshake, LOAD_A captures A = in_data, LOAD_B captures B = in_data and LOAD_OP captures opcode = in_data[2:0]; upper in_data bits in LOAD_OP are ignored.
REQ-018 Opcodes:
- 000 ADD: zero-extended A+B, carry in bit WIDTH.
- 001 SUB: (A-B) mod 2^WIDTH, upper bits 0.
- 010 AND, 011 OR, 100 XOR: bitwise, upper bits 0.
- 101 MUL: unsigned A*B, full 2*WIDTH bits.
- 110 PASS: result = A.
- 111: reserved.
REQ-019 Single-cycle ops SHALL register result in EXEC; out_valid SHALL rise the cycle after EXEC, i.e. 2 clocks after the opcode handshake edge.
REQ-020 MUL SHALL use iterative shift-add, one multiplier bit per cycle, clearing the accumulator in EXEC; out_valid SHALL rise WIDTH+2 clocks after the opcode handshake edge.
REQ-021 In DONE, out_valid SHALL be high, and result and error SHALL hold stable until out_ready is sampled high.
REQ-022 If out_ready is high on the first DONE cycle, out_valid SHALL last exactly one cycle.
REQ-023 Reserved opcode 111 SHALL go EXEC -> DONE with result = 0 and error = 1; error SHALL be 0 for all other opcodes.
REQ-024 start outside IDLE SHALL be ignored, including start in DONE coincident with out_ready.
REQ-025 abort SHALL take priority over every other event; the next state SHALL be IDLE, with out_valid = 0 and error = 0 from that edge.
REQ-026 abort SHALL leave A, B and result undefined for observation; the MUL counter SHALL be cleared.
REQ-027 A start that coincides with abort SHALL be ignored.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 Operand registers SHALL change only on their own load handshake.

Reset
REQ-030 While rst_n is low, the state SHALL be IDLE, and A, B, opcode, result, accumulator and counter SHALL be 0.
REQ-031 While rst_n is low, in_ready, out_valid, error and busy SHALL all be 0.
REQ-032 Reset asserted mid-transaction, including in MUL, SHALL discard it; after release the block SHALL wait for a new start.
REQ-033 Reset deassertion SHALL be synchronised; the first state change SHALL be no earlier than the second rising clk edge after deassertion.

Verification (WIDTH = 8)
REQ-034 ADD with carry: start; words 0xF0, 0x20, 0x00 with in_valid held high; out_ready = 1 -> result = 0x0110, error = 0, out_valid high exactly 1 cycle, 2 clocks after the opcode edge.
REQ-035 MUL with backpressure: A = 0xFF, B = 0xFF, op = 101; out_ready = 0 for 5 cycles -> out_valid rises 10 clocks after the opcode edge; result = 0xFE01 held stable until out_ready.
REQ-036 SUB wrap plus input stall: A = 0x03, B = 0x05, op = 001, in_valid low 3 cycles between each word -> in_ready stays high while waiting; result = 0x00FE.
REQ-037 Reserved opcode: op = 0x07 with in_data = 0xFF -> error = 1, result = 0.
REQ-038 Follow-on after reserved opcode: next transaction ADD 1+1 -> error = 0, result = 0x0002.
REQ-039 Abort mid-MUL: abort asserted in the 4th MUL cycle -> next cycle busy = 0 and out_valid never rises; a following start runs XOR 0xAA^0x0F -> result = 0x00A5.
REQ-040 Async reset in LOAD_B: rst_n low mid-cycle -> all outputs 0 immediately; start ignored while reset is low.
REQ-041 Start ignored when busy: start pulsed in LOAD_A and in DONE -> no state disturbance.

Source files
------------

// File: rtl/fsm_calc_stream.sv
// Streaming calculator: loads A, B and an opcode over a valid/ready input,
// computes one result (iterative shift-add for MUL) and holds it until out_ready.
// Ports: clk, rst_n (async, active-low), start, abort, in_valid/in_data/in_ready,
//        out_valid/out_ready, result[2*WIDTH-1:0], error, busy.
module fsm_calc_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               error,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [1:0]         sync_q;

    logic               run;
    logic               hs;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [WIDTH-1:0]   b_sh;

    // Reset release is synchronised; start is ignored until it has
    // propagated through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign run   = sync_q[1];
    assign ext_a = {{WIDTH{1'b0}}, a_q};
    assign ext_b = {{WIDTH{1'b0}}, b_q};
    assign b_sh  = b_q >> cnt_q;

    assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                       (state_q == S_LOAD_OP);
    assign hs        = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign error     = err_q && (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = res_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && run) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                if (hs) begin
                    a_d     = in_data;
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (hs) begin
                    b_d     = in_data;
                    state_d = S_LOAD_OP;
                end
            end
            S_LOAD_OP: begin
                if (hs) begin
                    op_d    = in_data[2:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                acc_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_DONE;
                unique case (op_q)
                    OP_ADD:  res_d = ext_a + ext_b;
                    OP_SUB:  res_d = {{WIDTH{1'b0}}, a_q - b_q};
                    OP_AND:  res_d = ext_a & ext_b;
                    OP_OR:   res_d = ext_a | ext_b;
                    OP_XOR:  res_d = ext_a ^ ext_b;
                    OP_MUL:  state_d = S_MUL;
                    OP_PASS: res_d = ext_a;
                    default: begin
                        res_d = '0;
                        err_d = 1'b1;
                    end
                endcase
            end
            S_MUL: begin
                // One multiplier bit per cycle, LSB first.
                if (b_sh[0]) acc_d = acc_q + (ext_a << cnt_q);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    res_d   = acc_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fsm_calc_stream.sv
// Randomised self-checking bench for fsm_calc_stream (WIDTH = 8).
// Results are compared with an arithmetic reference model.
module tb_fsm_calc_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic         error;
    logic         busy;

    int checks = 0;
    int errors = 0;

    fsm_calc_stream #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .error     (error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: {error, result} from the opcode table.
    function automatic logic [16:0] ref_calc(input int a, input int b,
                                             input int op);
        int r;
        logic e;
        e = 1'b0;
        case (op)
            0: r = a + b;
            1: r = (a - b) & 255;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * b;
            6: r = a;
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, r[15:0]};
    endfunction

    function automatic int ref_lat(input int op);
        return (op == 5) ? W + 2 : 2;
    endfunction

    task automatic send_word(input logic [W-1:0] w, input int gap,
                             output bit rdy_ok);
        int t;
        rdy_ok = 1'b1;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            if (!in_ready) rdy_ok = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] opw, input int gap,
                           input int hold, output logic [15:0] res,
                           output logic err, output int lat,
                           output bit stable, output bit ov_after,
                           output bit rdy_ok);
        bit r;
        rdy_ok = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(a, gap, r);   rdy_ok &= r;
        send_word(b, gap, r);   rdy_ok &= r;
        send_word(opw, gap, r); rdy_ok &= r;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        err = error;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || result !== res || error !== err) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ov_after = out_valid;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, error, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {in_ready, out_valid, error, busy});
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result got=%h exp=0000", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_add_carry();
        logic [15:0] res; logic err; int lat; bit st, ova, rk;
        run_txn(8'hF0, 8'h20, 8'h00, 0, 0, res, err, lat, st, ova, rk);
        checks++;
        if (res !== 16'h0110 || err !== 1'b0) begin
            errors++;
            $display("FAIL add_carry got=%h/%b exp=0110/0", res, err);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL add_latency got=%0d exp=2", lat);
        end
        checks++;
        if (ova !== 1'b0) begin
            errors++;
            $display("FAIL add_one_cycle out_valid got=%b exp=0", ova);
        end
    endtask

    task automatic test_mul_backpressure();
        logic [15:0] res; logic err; int lat; bit st, ova, rk;
        run_txn(8'hFF, 8'hFF, 8'h05, 0, 5, res, err, lat, st, ova, rk);
        checks++;
        if (res !== 16'hFE01 || err !== 1'b0) begin
            errors++;
            $display("FAIL mul_result got=%h/%b exp=fe01/0", res, err);
        end
        checks++;
        if (lat != W + 2) begin
            errors++;
            $display("FAIL mul_latency got=%0d exp=%0d", lat, W + 2);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL mul_hold_stable got=0 exp=1");
        end
        checks++;
        if (ova !== 1'b0) begin
            errors++;
            $display("FAIL mul_release out_valid got=%b exp=0", ova);
        end
    endtask

    task automatic test_sub_stall();
        logic [15:0] res; logic err; int lat; bit st, ova, rk;
        run_txn(8'h03, 8'h05, 8'h01, 3, 0, res, err, lat, st, ova, rk);
        checks++;
        if (res !== 16'h00FE || err !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap got=%h/%b exp=00fe/0", res, err);
        end
        checks++;
        if (!rk) begin
            errors++;
            $display("FAIL sub_stall in_ready got=0 exp=1");
        end
    endtask

    task automatic test_reserved_and_follow();
        logic [15:0] res; logic err; int lat; bit st, ova, rk;
        run_txn(8'h12, 8'h34, 8'hFF, 0, 1, res, err, lat, st, ova, rk);
        checks++;
        if (res !== 16'h0000 || err !== 1'b1) begin
            errors++;
            $display("FAIL reserved got=%h/%b exp=0000/1", res, err);
        end
        run_txn(8'h01, 8'h01, 8'h00, 0, 0, res, err, lat, st, ova, rk);
        checks++;
        if (res !== 16'h0002 || err !== 1'b0) begin
            errors++;
            $display("FAIL follow_on got=%h/%b exp=0002/0", res, err);
        end
    endtask

    task automatic test_abort_mul();
        logic [15:0] res; logic err; int lat; bit st, ova, rk, r, seen;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(8'h37, 0, r);
        send_word(8'h59, 0, r);
        send_word(8'h05, 0, r);
        // EXEC cycle, then three MUL cycles; abort lands in the fourth.
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy/ov/err got=%b%b%b exp=000",
                     busy, out_valid, error);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet got=active exp=idle");
        end
        run_txn(8'hAA, 8'h0F, 8'h04, 0, 0, res, err, lat, st, ova, rk);
        checks++;
        if (res !== 16'h00A5 || err !== 1'b0) begin
            errors++;
            $display("FAIL abort_follow_xor got=%h/%b exp=00a5/0", res, err);
        end
    endtask

    task automatic test_reset_load_b();
        logic [15:0] res; logic err; int lat; bit st, ova, rk, r;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(8'h44, 0, r);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, error, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got=%b exp=0000",
                     {in_ready, out_valid, error, busy});
        end
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_reset busy got=%b exp=0", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_first_edge busy got=%b exp=0", busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_start busy got=%b exp=0", busy);
        end
        run_txn(8'h21, 8'h0C, 8'h06, 0, 0, res, err, lat, st, ova, rk);
        checks++;
        if (res !== 16'h0021 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pass got=%h/%b exp=0021/0", res, err);
        end
    endtask

    task automatic test_start_busy();
        bit r;
        int t;
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_in_load_a busy/rdy got=%b%b exp=11",
                     busy, in_ready);
        end
        send_word(8'h12, 0, r);
        send_word(8'h34, 0, r);
        send_word(8'h00, 0, r);
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (result !== 16'h0046 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_busy_result got=%h/%b exp=0046/1",
                     result, out_valid);
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done busy/ov got=%b%b exp=00",
                     busy, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_later busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_random();
        logic [15:0] res; logic err; int lat; bit st, ova, rk;
        logic [16:0] exp;
        logic [W-1:0] a, b, opw;
        int op;
        for (int n = 0; n < 40; n++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            op  = $urandom_range(0, 7);
            opw = W'({$urandom_range(0, 31), op[2:0]});
            exp = ref_calc(int'(a), int'(b), op);
            run_txn(a, b, opw, $urandom_range(0, 2), $urandom_range(0, 3),
                    res, err, lat, st, ova, rk);
            checks++;
            if ({err, res} !== exp || lat != ref_lat(op) || !st || ova) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got=%b/%h lat=%0d st=%b ov=%b exp=%b/%h lat=%0d",
                         n, op, a, b, err, res, lat, st, ova,
                         exp[16], exp[15:0], ref_lat(op));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_mul_backpressure();
        test_sub_stall();
        test_reserved_and_follow();
        test_abort_mul();
        test_reset_load_b();
        test_start_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
